basic_gates: RTL and testbench

- Registered two-input logic-gate evaluator: computes all seven basic gate functions of operands a and b in parallel.
- Presents the results as one packed output bus y.
- Used as a small leaf utility and as a bring-up/teaching block.
- One pipeline register stage with a simple valid qualifier; default configuration is single-bit operands and a 7-bit result.

---
 rtl/basic_gates_pkg.sv | 22 ++
 rtl/basic_gates_lane.sv | 24 ++
 rtl/basic_gates.sv | 44 ++++
 tb/tb_basic_gates.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/basic_gates_pkg.sv
// Shared constants and types for the basic_gates evaluator.
package basic_gates_pkg;

    localparam int unsigned NUM_GATES = 7;

    // Result lane indices; lane g occupies y[g*WIDTH +: WIDTH].
    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_NOT  = 3'd2,
        GATE_NAND = 3'd3,
        GATE_NOR  = 3'd4,
        GATE_XOR  = 3'd5,
        GATE_XNOR = 3'd6
    } gate_e;

    // Least-significant bit position of a gate's lane in the packed bus.
    function automatic int unsigned lane_lsb(input gate_e g, input int unsigned width);
        return int'(g) * width;
    endfunction

endpackage

// File: rtl/basic_gates_lane.sv
// Combinational evaluation of all seven gate functions, bitwise over WIDTH.
module basic_gates_lane
    import basic_gates_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic [NUM_GATES*WIDTH-1:0] y
);

    // Pack each gate result into its lane of the output bus.
    always_comb begin
        y = '0;
        y[lane_lsb(GATE_AND,  WIDTH) +: WIDTH] = a & b;
        y[lane_lsb(GATE_OR,   WIDTH) +: WIDTH] = a | b;
        y[lane_lsb(GATE_NOT,  WIDTH) +: WIDTH] = ~a;
        y[lane_lsb(GATE_NAND, WIDTH) +: WIDTH] = ~(a & b);
        y[lane_lsb(GATE_NOR,  WIDTH) +: WIDTH] = ~(a | b);
        y[lane_lsb(GATE_XOR,  WIDTH) +: WIDTH] = a ^ b;
        y[lane_lsb(GATE_XNOR, WIDTH) +: WIDTH] = ~(a ^ b);
    end

endmodule

// File: rtl/basic_gates.sv
// Registered two-input gate evaluator with a one-cycle valid qualifier.
module basic_gates
    import basic_gates_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       in_valid,
    output logic [NUM_GATES*WIDTH-1:0] y,
    output logic                       out_valid
);

    logic [NUM_GATES*WIDTH-1:0] gate_res;

    basic_gates_lane #(
        .WIDTH (WIDTH)
    ) u_lane (
        .a (a),
        .b (b),
        .y (gate_res)
    );

    // Result register: load only on a valid sample so y holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (in_valid) begin
            y <= gate_res;
        end
    end

    // Valid flop: marks the cycle in which y carries a fresh result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_basic_gates.sv
// Randomized and directed checks of basic_gates at WIDTH=1 and WIDTH=4.
module tb_basic_gates;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, b1, iv1;
    logic [6:0] y1;
    logic       ov1;
    logic [3:0] a4, b4;
    logic       iv4;
    logic [27:0] y4;
    logic       ov4;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp1, exp4;
    logic        ev1, ev4;

    // Truth table per gate, bit index = {a,b}: AND, OR, NOT a, NAND, NOR, XOR, XNOR.
    localparam logic [3:0] TT [7] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111,
                                      4'b0001, 4'b0110, 4'b1001};

    always #5 clk = ~clk;

    basic_gates #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .in_valid  (iv1),
        .y         (y1),
        .out_valid (ov1)
    );

    basic_gates #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a4),
        .b         (b4),
        .in_valid  (iv4),
        .y         (y4),
        .out_valid (ov4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_y(input logic [3:0] a, input logic [3:0] b, input int w);
        logic [31:0] r;
        logic [3:0]  t;
        r = '0;
        for (int g = 0; g < 7; g++) begin
            t = TT[g];
            for (int i = 0; i < w; i++) begin
                r[g*w + i] = t[int'(a[i]) * 2 + int'(b[i])];
            end
        end
        return r;
    endfunction

    // One clock edge: update the model from the values presented, then compare.
    task automatic tick(input string tag);
        logic       s_rst, s_iv1, s_iv4;
        logic [3:0] sa1, sb1, sa4, sb4;
        s_rst = rst_n;
        s_iv1 = iv1; s_iv4 = iv4;
        sa1 = {3'b0, a1}; sb1 = {3'b0, b1};
        sa4 = a4; sb4 = b4;
        @(posedge clk);
        if (s_rst) begin
            if (s_iv1) exp1 = ref_y(sa1, sb1, 1);
            ev1 = s_iv1;
            if (s_iv4) exp4 = ref_y(sa4, sb4, 4);
            ev4 = s_iv4;
        end
        #1;
        check({tag, ".y1"},  {25'b0, y1}, exp1);
        check({tag, ".ov1"}, {31'b0, ov1}, {31'b0, ev1});
        check({tag, ".y4"},  {4'b0, y4}, exp4);
        check({tag, ".ov4"}, {31'b0, ov4}, {31'b0, ev4});
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        exp1 = '0; exp4 = '0; ev1 = 1'b0; ev4 = 1'b0;
        #1;
        check("async_rst.y1",  {25'b0, y1}, 32'h0);
        check("async_rst.ov1", {31'b0, ov1}, 32'h0);
        check("async_rst.y4",  {4'b0, y4}, 32'h0);
        check("async_rst.ov4", {31'b0, ov4}, 32'h0);
    endtask

    logic [6:0]  tt_exp [4];
    logic [1:0]  ab;

    initial begin
        tt_exp[0] = 7'h5C; tt_exp[1] = 7'h2E; tt_exp[2] = 7'h2A; tt_exp[3] = 7'h43;
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; iv4 = 1'b1;
        #1;
        assert_reset();
        tick("in_reset0");
        tick("in_reset1");

        // Release between edges; the first capture is the next rising edge.
        rst_n = 1'b1;
        iv4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ab = 2'(k);
            a1 = ab[1]; b1 = ab[0]; iv1 = 1'b1;
            tick("truth");
            check("truth_const", {25'b0, y1}, {25'b0, tt_exp[k]});
        end

        // Hold: invalid samples with toggling operands must not move y.
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        tick("hold_load");
        for (int k = 0; k < 5; k++) begin
            iv1 = 1'b0;
            a1 = ~a1; b1 = (k % 2 == 0);
            tick("hold");
            check("hold_const", {25'b0, y1}, 32'h43);
        end
        iv1 = 1'b0; a1 = 1'bx; b1 = 1'bx;
        tick("x_hold");
        check("x_hold_const", {25'b0, y1}, 32'h43);

        // Mid-stream reset between two valid samples.
        a1 = 1'b0; b1 = 1'b0; iv1 = 1'b1;
        tick("pre_rst");
        assert_reset();
        a1 = 1'b1; b1 = 1'b0;
        tick("mid_rst");
        rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b1; iv1 = 1'b1;
        tick("post_rst");
        check("post_rst_const", {25'b0, y1}, 32'h2E);

        // Wide operands.
        a4 = 4'b0101; b4 = 4'b0011; iv4 = 1'b1; iv1 = 1'b0;
        tick("w4");
        check("w4_const", {4'b0, y4},
              {4'b0, 4'b1001, 4'b0110, 4'b1000, 4'b1110, 4'b1010, 4'b0111, 4'b0001});

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 300; n++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); iv1 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom); iv4 = ($urandom_range(3) != 0);
            if ($urandom_range(40) == 0) begin
                assert_reset();
                tick("rand_rst");
                rst_n = 1'b1;
            end
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
